clic_irq_arbiter: RTL

//   Arbitrates CLIC-style interrupt sources into the one-hot irq request + 8-bit level consumed by the ID stage.

---
 rtl/clic_irq_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/clic_irq_arbiter.sv
// CLIC-style interrupt arbiter: picks the highest-level eligible source,
// holds it until acknowledged, pulses edge pending-clear, then enforces a gap.
module clic_irq_arbiter #(
    parameter int unsigned NumSrc    = 64,
    parameter int unsigned GapCycles = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumSrc-1:0]   pend_i,
    input  logic [NumSrc-1:0]   ie_i,
    input  logic [NumSrc-1:0]   edge_i,
    input  logic [NumSrc*8-1:0] level_i,
    input  logic                mie_i,
    input  logic                clear_i,
    input  logic                irq_ack_i,
    output logic [NumSrc-1:0]   irq_o,
    output logic [7:0]          irq_level_o,
    output logic [NumSrc-1:0]   clr_pend_o,
    output logic                busy_o
);

    localparam int unsigned IdWidth  = $clog2(NumSrc);
    localparam int unsigned CntWidth = $clog2(GapCycles + 1);

    typedef enum logic [1:0] {
        Idle,
        Req,
        Gap
    } state_e;

    state_e               state_q, state_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic                 edge_q, edge_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [NumSrc-1:0]    irq_d, clr_d;
    logic [7:0]           lvl_d;

    logic                 win_valid;
    logic [IdWidth-1:0]   win_id;
    logic [7:0]           win_lvl;
    logic                 arb;

    function automatic logic [NumSrc-1:0] onehot(input logic [IdWidth-1:0] id);
        onehot     = '0;
        onehot[id] = 1'b1;
    endfunction

    // Ascending scan with >= makes the highest id win a level tie.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_lvl   = '0;
        for (int unsigned i = 0; i < NumSrc; i++) begin
            if (pend_i[i] && ie_i[i] && mie_i &&
                (level_i[8*i +: 8] != 8'd0) &&
                (level_i[8*i +: 8] >= win_lvl)) begin
                win_valid = 1'b1;
                win_id    = IdWidth'(i);
                win_lvl   = level_i[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        edge_d  = edge_q;
        cnt_d   = cnt_q;
        irq_d   = irq_o;
        lvl_d   = irq_level_o;
        clr_d   = '0;
        arb     = 1'b0;
        unique case (state_q)
            Idle: arb = !clear_i;
            Req: begin
                if (irq_ack_i) begin
                    state_d = Gap;
                    cnt_d   = CntWidth'(GapCycles - 1);
                    irq_d   = '0;
                    lvl_d   = '0;
                    clr_d   = edge_q ? onehot(id_q) : '0;
                end else if (clear_i) begin
                    state_d = Idle;
                    irq_d   = '0;
                    lvl_d   = '0;
                end
            end
            Gap: begin
                if (clear_i) begin
                    state_d = Idle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = Idle;
                    arb     = 1'b1;
                end
            end
            default: state_d = Idle;
        endcase
        if (arb && win_valid) begin
            state_d = Req;
            id_d    = win_id;
            edge_d  = edge_i[win_id];
            irq_d   = onehot(win_id);
            lvl_d   = win_lvl;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            id_q        <= '0;
            edge_q      <= 1'b0;
            cnt_q       <= '0;
            irq_o       <= '0;
            irq_level_o <= '0;
            clr_pend_o  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            edge_q      <= edge_d;
            cnt_q       <= cnt_d;
            irq_o       <= irq_d;
            irq_level_o <= lvl_d;
            clr_pend_o  <= clr_d;
        end
    end

    assign busy_o = (state_q != Idle);

endmodule
